// File: rtl/muldiv_pkg.sv
// muldiv_pkg
//   Shared definitions for the iterative multiply/divide unit:
//   operation encodings, sequencer state encodings, default XLEN and
//   small decode helpers used by muldiv_sequencer and muldiv_datapath.
package muldiv_pkg;

    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OP_MUL   = 3'd0,
        OP_MULHU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_REM   = 3'd4,
        OP_REMU  = 3'd5
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    // Encodings 6 and 7 are not defined operations and fall back to MUL.
    function automatic op_e norm_op(input logic [2:0] raw);
        op_e res;
        case (raw)
            3'd1:    res = OP_MULHU;
            3'd2:    res = OP_DIV;
            3'd3:    res = OP_DIVU;
            3'd4:    res = OP_REM;
            3'd5:    res = OP_REMU;
            default: res = OP_MUL;
        endcase
        return res;
    endfunction

    function automatic logic is_div_op(input op_e o);
        return (o == OP_DIV) || (o == OP_DIVU) || (o == OP_REM) || (o == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// muldiv_datapath
//   Shift-add multiplier / restoring divider datapath. One iteration per
//   cycle while 'step' is high; operands are captured on 'load' and the
//   final sign correction / half selection happens on 'fix'.
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   load, step, fix strobes from the sequencer FSM
//   op, a, b        latched operation and operands
//   div_zero        combinational: divide-type op with zero divisor
//   res             result register (special value after load, final after fix)
module muldiv_datapath
    import muldiv_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            step,
    input  logic            fix,
    input  op_e             op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            div_zero,
    output logic [XLEN-1:0] res
);

    localparam int W2 = 2 * XLEN;

    // acc: product (MUL) or partial remainder (DIV)
    // mcand: shifted multiplicand (MUL) or divisor magnitude (DIV)
    // sh: multiplier shifted right (MUL) or dividend/quotient shifted left (DIV)
    logic [W2-1:0]   acc;
    logic [W2-1:0]   mcand;
    logic [XLEN-1:0] sh;
    logic            q_neg;
    logic            r_neg;

    logic            is_div;
    logic            is_signed;
    logic            is_rem;
    logic            neg_a;
    logic            neg_b;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;
    logic [XLEN-1:0] special_res;
    logic [W2-1:0]   add_sum;
    logic [W2-1:0]   r_shift;
    logic [W2-1:0]   r_sub;
    logic            r_ge;
    logic [XLEN-1:0] fix_val;

    // Operand decode: the divider works on magnitudes, signs are restored in FIX.
    always_comb begin
        is_div      = is_div_op(op);
        is_signed   = (op == OP_DIV) || (op == OP_REM);
        is_rem      = (op == OP_REM) || (op == OP_REMU);
        div_zero    = is_div && (b == '0);
        neg_a       = is_signed && a[XLEN-1];
        neg_b       = is_signed && b[XLEN-1];
        mag_a       = neg_a ? -a : a;
        mag_b       = neg_b ? -b : b;
        special_res = '0;
        if (div_zero) begin
            special_res = is_rem ? a : '1;
        end
    end

    // One iteration of each algorithm; the divider shifts the next dividend
    // bit into the remainder and subtracts only when it fits.
    always_comb begin
        add_sum = acc + (sh[0] ? mcand : '0);
        r_shift = {acc[W2-2:0], sh[XLEN-1]};
        r_sub   = r_shift - mcand;
        r_ge    = (r_shift >= mcand);
    end

    // Final result selection and sign correction. The most-negative / -1
    // case falls out naturally: magnitude 2^(XLEN-1) with no negation.
    always_comb begin
        case (op)
            OP_MULHU:        fix_val = acc[W2-1:XLEN];
            OP_DIV, OP_DIVU: fix_val = q_neg ? -sh : sh;
            OP_REM, OP_REMU: fix_val = r_neg ? -acc[XLEN-1:0] : acc[XLEN-1:0];
            default:         fix_val = acc[XLEN-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc   <= '0;
            mcand <= '0;
            sh    <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            res   <= '0;
        end else if (load) begin
            acc   <= '0;
            sh    <= is_div ? mag_a : b;
            mcand <= is_div ? {{XLEN{1'b0}}, mag_b} : {{XLEN{1'b0}}, a};
            q_neg <= neg_a ^ neg_b;
            r_neg <= neg_a;
            res   <= special_res;
        end else if (step) begin
            if (is_div) begin
                acc <= r_ge ? r_sub : r_shift;
                sh  <= {sh[XLEN-2:0], r_ge};
            end else begin
                acc   <= add_sum;
                mcand <= mcand << 1;
                sh    <= sh >> 1;
            end
        end else if (fix) begin
            res <= fix_val;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle controller for iterative MUL/MULHU/DIV/DIVU/REM/REMU in the
//   EX stage. Holds the pipeline with 'stall' while an operation runs and
//   presents the result with a one-cycle 'done' pulse.
// Ports
//   clk, rst      clock, asynchronous active-low reset
//   start, kill   new-op request (IDLE only) / flush that aborts any op
//   op, a, b      operation code and operands
//   stall, busy   pipeline hold / unit not idle
//   done, result  completion pulse and result (held until next accepted op)
// Configuration
//   MULDIV_ZERO_BYPASS_EN  when defined, ops with a zero operand that force a
//                          zero result skip the iterations (latency 2).
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_e          state;
    state_e          state_next;
    logic [CNT_W-1:0] cnt;
    op_e             op_q;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;

    logic            latch_en;
    logic            dp_load;
    logic            dp_step;
    logic            dp_fix;
    logic            cnt_clr;
    logic            cnt_inc;
    logic            finish;
    logic            skip_run;
    logic            dp_div_zero;
    logic [XLEN-1:0] dp_res;

    muldiv_datapath #(
        .XLEN (XLEN)
    ) u_datapath (
        .clk      (clk),
        .rst      (rst),
        .load     (dp_load),
        .step     (dp_step),
        .fix      (dp_fix),
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .div_zero (dp_div_zero),
        .res      (dp_res)
    );

    // Ops whose result is fully known after PREP jump straight to DONE.
`ifdef MULDIV_ZERO_BYPASS_EN
    always_comb begin
        if (is_div_op(op_q)) begin
            skip_run = dp_div_zero || (a_q == '0);
        end else begin
            skip_run = (a_q == '0) || (b_q == '0);
        end
    end
`else
    assign skip_run = dp_div_zero;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // kill overrides every state, including a simultaneous start in IDLE.
    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        dp_load    = 1'b0;
        dp_step    = 1'b0;
        dp_fix     = 1'b0;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        finish     = 1'b0;
        if (kill) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        latch_en   = 1'b1;
                        state_next = S_PREP;
                    end
                end
                S_PREP: begin
                    dp_load    = 1'b1;
                    cnt_clr    = 1'b1;
                    state_next = skip_run ? S_DONE : S_RUN;
                end
                S_RUN: begin
                    dp_step = 1'b1;
                    cnt_inc = 1'b1;
                    if (cnt == CNT_LAST) begin
                        state_next = S_FIX;
                    end
                end
                S_FIX: begin
                    dp_fix     = 1'b1;
                    state_next = S_DONE;
                end
                S_DONE: begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
                default: state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            op_q <= OP_MUL;
            a_q  <= '0;
            b_q  <= '0;
        end else begin
            if (latch_en) begin
                op_q <= norm_op(op);
                a_q  <= a;
                b_q  <= b;
            end
            if (cnt_clr) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // The result register only moves when an op completes without a kill,
    // so a flushed op leaves the previous result visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done   <= 1'b0;
            result <= '0;
        end else begin
            done <= finish;
            if (finish) begin
                result <= dp_res;
            end
        end
    end

    assign busy  = (state != S_IDLE);
    assign stall = start || (state == S_PREP) || (state == S_RUN) || (state == S_FIX);

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 3;
    localparam int MAX_WAIT = 200;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        kill;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        stall;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] last_result = '0;

    muldiv_sequencer #(
        .XLEN  (XLEN),
        .CNT_W (6)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .kill   (kill),
        .op     (op),
        .a      (a),
        .b      (b),
        .stall  (stall),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference behaviour from RISC-V M-extension semantics.
    function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [63:0] p;
        longint      sx;
        longint      sy;
        longint      q;
        logic [31:0] r;
        p  = {32'b0, x} * {32'b0, y};
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (o)
            3'd1: r = p[63:32];
            3'd2: begin
                if (y == 0) r = 32'hFFFF_FFFF;
                else begin q = sx / sy; r = q[31:0]; end
            end
            3'd3: r = (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd4: begin
                if (y == 0) r = x;
                else begin q = sx % sy; r = q[31:0]; end
            end
            3'd5: r = (y == 0) ? x : x % y;
            default: r = p[31:0];
        endcase
        return r;
    endfunction

    function automatic int expLatency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        logic isDiv;
        int   lat;
        isDiv = (o >= 3'd2) && (o <= 3'd5);
        lat   = LAT;
        if (isDiv && y == 0) lat = 2;
`ifdef MULDIV_ZERO_BYPASS_EN
        if (isDiv && x == 0) lat = 2;
        if (!isDiv && (x == 0 || y == 0)) lat = 2;
`endif
        return lat;
    endfunction

    // Called just after the accepting edge; counts edges until done rises.
    task automatic waitDone(input int lat, output int n, output logic stallOk);
        n = 0;
        stallOk = 1'b1;
        while (!done && n < MAX_WAIT) begin
            if (n <= lat - 2 && !stall) stallOk = 1'b0;
            if (n == lat - 1 && stall) stallOk = 1'b0;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic applyStimulus(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        int          n;
        int          lat;
        logic        stallOk;
        logic [31:0] exp;
        lat = expLatency(o, x, y);
        exp = refModel(o, x, y);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        #1;
        checkOutput({tag, "/stall_on_start"}, 64'(stall), 64'd1);
        @(posedge clk); #1;
        start = 1'b0;
        waitDone(lat, n, stallOk);
        checkOutput({tag, "/latency"}, 64'(n), 64'(lat));
        checkOutput({tag, "/result"}, 64'(result), 64'(exp));
        checkOutput({tag, "/stall"}, 64'(stallOk), 64'd1);
        last_result = exp;
        @(posedge clk); #1;
        checkOutput({tag, "/done_pulse"}, 64'(done), 64'd0);
    endtask

    function automatic logic [31:0] pickOperand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0:       v = 32'h0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom_range(0, 15));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int          n;
        logic        stallOk;
        logic        sawDone;
        logic [2:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;

        rst = 1'b0; start = 1'b0; kill = 1'b0; op = '0; a = '0; b = '0;
        #12;
        checkOutput("reset/busy", 64'(busy), 64'd0);
        checkOutput("reset/done", 64'(done), 64'd0);
        checkOutput("reset/result", 64'(result), 64'd0);
        checkOutput("reset/stall", 64'(stall), 64'd0);
        @(negedge clk); rst = 1'b1;

        applyStimulus("mul_7x6", 3'd0, 32'd7, 32'd6);
        applyStimulus("div_neg20_3", 3'd2, 32'hFFFF_FFEC, 32'd3);
        applyStimulus("rem_neg20_3", 3'd4, 32'hFFFF_FFEC, 32'd3);
        applyStimulus("divu_by0", 3'd3, 32'd100, 32'd0);
        applyStimulus("remu_by0", 3'd5, 32'd100, 32'd0);
        applyStimulus("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus("rem_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        applyStimulus("mulhu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        applyStimulus("mul_a0", 3'd0, 32'd0, 32'd1234);
        applyStimulus("divu_a0", 3'd3, 32'd0, 32'd9);

        // kill during RUN: no done, result keeps old value
        @(negedge clk);
        op = 3'd0; a = 32'd11; b = 32'd13; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        checkOutput("kill/busy", 64'(busy), 64'd0);
        sawDone = done;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) sawDone = 1'b1;
        end
        checkOutput("kill/no_done", 64'(sawDone), 64'd0);
        checkOutput("kill/result_held", 64'(result), 64'(last_result));
        applyStimulus("after_kill", 3'd3, 32'd1000, 32'd7);

        // kill and start together in IDLE: kill wins
        @(negedge clk);
        op = 3'd0; a = 32'd3; b = 32'd3; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        checkOutput("kill_start/busy", 64'(busy), 64'd0);

        // start while busy is ignored
        @(negedge clk);
        op = 3'd0; a = 32'd7; b = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        op = 3'd3; a = 32'd100; b = 32'd0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        waitDone(LAT - 6, n, stallOk);
        checkOutput("busy_start/latency", 64'(n + 6), 64'(LAT));
        checkOutput("busy_start/result", 64'(result), 64'd42);
        last_result = 32'd42;
        @(posedge clk); #1;
        checkOutput("busy_start/idle", 64'(busy), 64'd0);

        // asynchronous reset mid-RUN
        @(negedge clk);
        op = 3'd2; a = 32'd500; b = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        checkOutput("rst_mid/busy", 64'(busy), 64'd0);
        checkOutput("rst_mid/result", 64'(result), 64'd0);
        checkOutput("rst_mid/stall", 64'(stall), 64'd0);
        @(negedge clk); rst = 1'b1;
        last_result = '0;

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = pickOperand();
            rb = pickOperand();
            applyStimulus($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
